// File: rtl/soc_system_pll_reset_ctrl.sv
// soc_system_pll_reset_ctrl: pulses the PLL reset, then releases sys_rst once lock has been stable long enough.
// Define PLL_LOCK_TIMEOUT_EN to add the lock timeout, retry counter and FAIL state.
module soc_system_pll_reset_ctrl #(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int MAX_RETRIES         = 4
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       clr_status,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fail,
   output logic [7:0] lock_loss_cnt
);
   localparam logic [1:0] RESET_PLL = 2'd0, WAIT_LOCK = 2'd1, RUN = 2'd2, S_FAIL = 2'd3;
   localparam int CMAX = RST_PULSE_CYCLES > LOCK_STABLE_CYCLES ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
   localparam int CW = $clog2(CMAX + 1);
   logic [1:0] state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic sync1, lock_s, stable_done, timeout, give_up;
   logic [7:0] loss_n;
   assign stable_done = state == WAIT_LOCK && lock_s && cnt == CW'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_LOCK_TIMEOUT_EN
   localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmr;
   logic [7:0] retry;
   assign timeout = state == WAIT_LOCK && tmr == TW'(LOCK_TIMEOUT_CYCLES - 1);
   assign give_up = retry + 8'd1 == 8'(MAX_RETRIES);
`else
   assign timeout = 1'b0;
   assign give_up = 1'b0;
   assign fail = 1'b0;
`endif
   // cnt is the pulse counter in RESET_PLL and the stable counter in WAIT_LOCK;
   // re-entry loads 1 so the pulse lasts exactly RST_PULSE_CYCLES from the entry edge.
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      case (state)
         RESET_PLL: begin
            state_n = cnt == CW'(RST_PULSE_CYCLES) ? WAIT_LOCK : RESET_PLL;
            cnt_n = cnt == CW'(RST_PULSE_CYCLES) ? '0 : cnt + 1'b1;
         end
         WAIT_LOCK: begin
            state_n = stable_done ? RUN : timeout ? (give_up ? S_FAIL : RESET_PLL) : WAIT_LOCK;
            cnt_n = !stable_done && timeout ? CW'(1) : lock_s ? cnt + 1'b1 : '0;
         end
         RUN: begin
            state_n = lock_s ? RUN : RESET_PLL;
            cnt_n = CW'(1);
         end
         default: cnt_n = cnt;
      endcase
      loss_n = clr_status ? 8'd0 : lock_loss_cnt;
      if (state == RUN && !lock_s && loss_n != 8'hFF) loss_n = loss_n + 8'd1;
   end
   always_ff @(posedge refclk) begin
      sync1 <= pll_locked;
      lock_s <= sync1;
      if (rst) begin
         state <= RESET_PLL;
         cnt <= '0;
         pll_rst <= 1'b1;
         sys_rst <= 1'b1;
         ready <= 1'b0;
         lock_loss_cnt <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         pll_rst <= state_n == RESET_PLL || state_n == S_FAIL;
         sys_rst <= state_n != RUN;
         ready <= state_n == RUN;
         lock_loss_cnt <= loss_n;
      end
   end
`ifdef PLL_LOCK_TIMEOUT_EN
   // Stable completion beats a coincident timeout, so no retry is charged then.
   always_ff @(posedge refclk) begin
      if (rst) begin
         tmr <= '0;
         retry <= '0;
         fail <= 1'b0;
      end else begin
         tmr <= state == WAIT_LOCK && state_n == WAIT_LOCK ? tmr + 1'b1 : '0;
         retry <= state_n == RUN ? 8'd0 : retry + {7'd0, timeout && !stable_done};
         fail <= state_n == S_FAIL;
      end
   end
`endif
endmodule

// File: doc/soc_system_pll_reset_ctrl.md
# soc_system_pll_reset_ctrl

Reset and lock supervisor for the fabric PLL. It runs on the free-running 50 MHz reference clock and drives the PLL's reset input. It watches the PLL's asynchronous `locked` output and releases a system reset to downstream logic only after lock has been stable for a programmed time. Loss of lock re-arms the PLL, and an optional timeout/retry mechanism declares a hard failure.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, 16: width of each `pll_rst` pulse, in cycles; must be ≥2.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release; must be ≥2.
- `LOCK_TIMEOUT_CYCLES`, 50000: cycles allowed in WAIT_LOCK (1 ms at 50 MHz); only used with the macro.
- `MAX_RETRIES`, 4: timeouts tolerated before entering FAIL, range 1–255; only used with the macro.

Ports:
- `refclk` in 1: reference clock, free-running; the sole clock of the block.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL lock indication, asynchronous to `refclk`.
- `clr_status` in 1: single-cycle pulse that clears `lock_loss_cnt`.
- `pll_rst` out 1: reset to the PLL, active-high.
- `sys_rst` out 1: active-high reset for downstream logic. Consumers resynchronize it into their own domains.
- `ready` out 1: high while in state RUN.
- `fail` out 1: high in state FAIL.
- `lock_loss_cnt` out 8: saturating count of lock losses seen while in RUN.

## Operation
- **Synchronizer:** `pll_locked` passes through a 2-flop synchronizer to give `lock_s`. Only `lock_s` is used internally.
- **Outputs:** all outputs are registered.
- **Reset values:**
  - state = RESET_PLL
  - `pll_rst` = 1, `sys_rst` = 1
  - `ready` = 0, `fail` = 0
  - `lock_loss_cnt` = 0
  - all internal counters = 0
- **RESET_PLL:**
  - Outputs: `pll_rst` = 1, `sys_rst` = 1, `ready` = 0.
  - Pulse counter counts to `RST_PULSE_CYCLES`, then the state goes to WAIT_LOCK.
- **WAIT_LOCK:**
  - Outputs: `pll_rst` = 0, `sys_rst` = 1.
  - Stable counter increments each cycle `lock_s` = 1 and clears on any cycle `lock_s` = 0.
  - When the counter reaches `LOCK_STABLE_CYCLES`, the state goes to RUN.
  - With the macro: a timeout counter runs from entry into WAIT_LOCK. When it reaches `LOCK_TIMEOUT_CYCLES`, the retry counter increments. If the retry counter then equals `MAX_RETRIES`, go to FAIL; otherwise go to RESET_PLL.
- **RUN:**
  - Outputs: `pll_rst` = 0, `sys_rst` = 0, `ready` = 1.
  - The retry counter clears on entry.
  - If `lock_s` = 0: `lock_loss_cnt` increments (saturating at 255) and the state goes to RESET_PLL.
- **FAIL:**
  - Outputs: `pll_rst` = 1, `sys_rst` = 1, `fail` = 1, `ready` = 0.
  - Exits only via `rst`.
- **Simultaneous events and boundaries:**
  - Stable completion and timeout in the same cycle: RUN wins and the retry counter is not incremented.
  - `clr_status` in the same cycle as a loss increment: the result is 1 (the clear applies first, then the increment).
  - `clr_status` at saturation (255): the result is 0.
  - Lock glitches in WAIT_LOCK restart the stable count only; they do not re-pulse `pll_rst`.
  - `rst` asserted in any state, including mid-pulse or mid-count: all reset values apply on the next edge, and a fresh full `RST_PULSE_CYCLES` pulse follows.

## Timing
- Input latency: `pll_locked` to `lock_s` is 2 cycles.
- `pll_rst` pulse: high for exactly `RST_PULSE_CYCLES` cycles per entry into RESET_PLL. After `rst` deasserts, the first pulse is `RST_PULSE_CYCLES` cycles counted from the first non-reset edge.
- Lock release: `sys_rst` falls and `ready` rises on the same edge, exactly `LOCK_STABLE_CYCLES` cycles after the first `lock_s` = 1 of an unbroken run. End to end, that is `LOCK_STABLE_CYCLES` + 2 cycles after `pll_locked` rises.
- Lock loss: `sys_rst` = 1, `ready` = 0 and `pll_rst` = 1 on the edge after `lock_s` first reads 0, which is 3 cycles after `pll_locked` falls. `lock_loss_cnt` updates on the same edge.
- Timeout: `pll_rst` rises on the edge after the `LOCK_TIMEOUT_CYCLES`-th WAIT_LOCK cycle. `fail` rises on that same edge instead when retries are exhausted.

## Configuration
- Macro: `PLL_LOCK_TIMEOUT_EN`.
- Defined: the timeout counter, retry counter and FAIL state are present, with behaviour as above.
- Undefined:
  - WAIT_LOCK waits indefinitely.
  - The timeout and retry counters and the FAIL state are not synthesized.
  - `fail` is tied to 0.
  - `LOCK_TIMEOUT_CYCLES` and `MAX_RETRIES` are ignored.

## Test plan
All scenarios use `RST_PULSE_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32, `MAX_RETRIES`=2.
- **Power-up:** release `rst`, raise `pll_locked` 10 cycles later → `pll_rst` high for exactly 4 cycles; `sys_rst` falls and `ready` rises exactly 10 cycles after `pll_locked` rises; `lock_loss_cnt` = 0.
- **Glitch during acquisition:** drop `pll_locked` for 1 cycle after 5 locked cycles in WAIT_LOCK → stable count restarts; release 10 cycles after the re-rise; no extra `pll_rst` pulse.
- **Loss in RUN:** drop `pll_locked` → 3 cycles later `sys_rst` = 1, `ready` = 0, `pll_rst` = 1 for 4 cycles, `lock_loss_cnt` = 1. Repeat 256 times → `lock_loss_cnt` holds 255. Pulse `clr_status` in the same cycle as a loss → `lock_loss_cnt` = 1.
- **Timeout/fail (macro defined):** hold `pll_locked` low → two 4-cycle `pll_rst` pulses, each followed by a 32-cycle wait; then `fail` = 1, `pll_rst` = 1, `sys_rst` = 1 held; raising `pll_locked` has no effect until `rst`.
- **No timeout (macro undefined):** hold `pll_locked` low for 1000 cycles → one 4-cycle pulse, `pll_rst` = 0 thereafter, `fail` = 0; a late lock still releases after 10 cycles.
- **Reset mid-operation:** assert `rst` for 1 cycle in RUN and again mid-pulse → all outputs return to reset values on the next edge, followed by a full 4-cycle `pll_rst` pulse.
